// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: SRAM read port, instruction handoff to decode, redirect and status.
interface instruction_fetch_if;
    logic [15:0] memAddress;
    logic [31:0] memData;
    logic [31:0] instr;
    logic [15:0] instrPC;
    logic        instrValid;
    logic        instrReady;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic        halted;
    logic [15:0] fetchCount;

    // Fetch unit side
    modport master (
        output memAddress, instr, instrPC, instrValid, halted, fetchCount,
        input  memData, instrReady, branchTaken, branchTarget
    );

    // Memory / decode side
    modport slave (
        input  memAddress, instr, instrPC, instrValid, halted, fetchCount,
        output memData, instrReady, branchTaken, branchTarget
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads a combinational SRAM at the PC, presents one
// registered instruction per cycle to decode, and stops on the halt opcode.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input logic              Clk,
    input logic              Reset,
    instruction_fetch_if.master bus
);
    // MEM_WORDS is a power of two, so wrap and target masking reduce to an AND.
    localparam logic [15:0] ADDR_MASK = 16'(MEM_WORDS - 1);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        halted_q, halted_d;

    logic        xfer;
    logic        slot_free;

    assign xfer      = instr_valid_q & bus.instrReady;
    assign slot_free = ~instr_valid_q | bus.instrReady;

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC & ADDR_MASK;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
        end
    end

    // Next state: a redirect always resumes RUN; a captured halt word stops fetch
    always_comb begin
        state_d = state_q;
        if (bus.branchTaken) begin
            state_d = RUN;
        end else if (state_q == RUN && slot_free && bus.memData[31:26] == HALT_OPCODE) begin
            state_d = HALTED;
        end
    end

    // Datapath next values: redirect flush, capture when the slot frees, drain in HALTED
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;

        // A transfer counts even when a redirect flushes the slot in the same cycle.
        if (xfer && fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        if (bus.branchTaken) begin
            pc_d          = bus.branchTarget & ADDR_MASK;
            instr_valid_d = 1'b0;
        end else if (state_q == RUN) begin
            if (slot_free) begin
                instr_d       = bus.memData;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = (pc_q + 16'd1) & ADDR_MASK;
            end
        end else if (xfer) begin
            instr_valid_d = 1'b0;
        end

        halted_d = (state_d == HALTED);
    end

    assign bus.memAddress = pc_q;
    assign bus.instr      = instr_q;
    assign bus.instrPC    = instr_pc_q;
    assign bus.instrValid = instr_valid_q;
    assign bus.fetchCount = fetch_count_q;
    assign bus.halted     = halted_q;
endmodule
